// File: rtl/i2c_xfer_sequencer.sv
// i2c_xfer_sequencer: drives the i2c_master register bus to run single-byte
// register writes/reads from a one-shot request, after a one-time core init.
module i2c_xfer_sequencer #(
    parameter logic [15:0] PRESCALE = 16'd99,
    parameter logic [15:0] TIMEOUT  = 16'd4095
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       req,
    input  logic       rnw,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wdata,
    output logic       ready,
    output logic       done,
    output logic [7:0] rdata,
    output logic [1:0] err,
    output logic [5:0] m_a,
    output logic [7:0] m_di,
    output logic       m_we,
    output logic       m_re,
    input  logic [7:0] m_do
);
    typedef enum logic [4:0] {
        INIT_LO, INIT_HI, INIT_EN, IDLE,
        SET_TXR, SET_CR, POLL_RD, POLL_WAIT, POLL_CHK,
        RX_RD, RX_WAIT, RX_CHK,
        STOP_CR, STOP_RD, STOP_WAIT, STOP_CHK,
        FINISH
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  phase_q, phase_d;
    logic [15:0] cnt_q, cnt_d;
    logic        rnw_q, rnw_d;
    logic [6:0]  dev_q, dev_d;
    logic [7:0]  reg_q, reg_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [1:0]  err_q, err_d;
    logic [5:0]  m_a_q, m_a_d;
    logic [7:0]  m_di_q, m_di_d;
    logic        m_we_q, m_we_d;
    logic        m_re_q, m_re_d;

    logic [7:0]  txr_val, cr_val;
    logic [15:0] cnt_inc;
    logic        last_phase, rx_phase;

    // Phase 0: address (W), 1: register index, 2: data (W) or address (R), 3: read byte
    assign txr_val    = phase_q == 2'd0 ? {dev_q, 1'b0} :
                        phase_q == 2'd1 ? reg_q :
                        rnw_q ? {dev_q, 1'b1} : wdata_q;
    assign cr_val     = phase_q == 2'd1 ? 8'h10 :
                        phase_q == 2'd3 ? 8'h68 :
                        (phase_q == 2'd2 && !rnw_q) ? 8'h50 : 8'h90;
    assign last_phase = rnw_q ? phase_q == 2'd3 : phase_q == 2'd2;
    assign rx_phase   = rnw_q && phase_q == 2'd3;
    assign cnt_inc    = cnt_q + 16'd1;

    assign ready = state_q == IDLE;
    assign done  = state_q == FINISH;
    assign rdata = rdata_q;
    assign err   = err_q;
    assign m_a   = m_a_q;
    assign m_di  = m_di_q;
    assign m_we  = m_we_q;
    assign m_re  = m_re_q;

    // Bus strobes are registered, so each state's access appears in the following cycle
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        rnw_d   = rnw_q;
        dev_d   = dev_q;
        reg_d   = reg_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        m_a_d   = m_a_q;
        m_di_d  = m_di_q;
        m_we_d  = 1'b0;
        m_re_d  = 1'b0;
        case (state_q)
            INIT_LO: begin
                m_we_d  = 1'b1;
                m_a_d   = 6'd0;
                m_di_d  = PRESCALE[7:0];
                state_d = INIT_HI;
            end
            INIT_HI: begin
                m_we_d  = 1'b1;
                m_a_d   = 6'd1;
                m_di_d  = PRESCALE[15:8];
                state_d = INIT_EN;
            end
            INIT_EN: begin
                m_we_d  = 1'b1;
                m_a_d   = 6'd2;
                m_di_d  = 8'h80;
                state_d = IDLE;
            end
            IDLE: begin
                if (req) begin
                    rnw_d   = rnw;
                    dev_d   = dev_addr;
                    reg_d   = reg_addr;
                    wdata_d = wdata;
                    rdata_d = 8'h00;
                    err_d   = 2'd0;
                    phase_d = 2'd0;
                    cnt_d   = 16'd0;
                    state_d = SET_TXR;
                end
            end
            SET_TXR: begin
                m_we_d  = 1'b1;
                m_a_d   = 6'd3;
                m_di_d  = txr_val;
                state_d = SET_CR;
            end
            SET_CR: begin
                m_we_d  = 1'b1;
                m_a_d   = 6'd4;
                m_di_d  = cr_val;
                state_d = POLL_RD;
            end
            POLL_RD: begin
                m_re_d  = 1'b1;
                m_a_d   = 6'd4;
                state_d = POLL_WAIT;
            end
            POLL_WAIT: state_d = POLL_CHK;
            POLL_CHK: begin
                if (m_do[5]) begin
                    err_d   = 2'd2;
                    state_d = FINISH;
                end else if (m_do[1]) begin
                    cnt_d   = cnt_inc;
                    err_d   = cnt_inc == TIMEOUT ? 2'd3 : err_q;
                    state_d = cnt_inc == TIMEOUT ? STOP_CR : POLL_RD;
                end else if (!rx_phase && m_do[7]) begin
                    err_d   = 2'd1;
                    state_d = STOP_CR;
                end else if (rx_phase) begin
                    state_d = RX_RD;
                end else if (last_phase) begin
                    state_d = FINISH;
                end else begin
                    phase_d = phase_q + 2'd1;
                    cnt_d   = 16'd0;
                    state_d = (rnw_q && phase_q == 2'd2) ? SET_CR : SET_TXR;
                end
            end
            RX_RD: begin
                m_re_d  = 1'b1;
                m_a_d   = 6'd3;
                state_d = RX_WAIT;
            end
            RX_WAIT: state_d = RX_CHK;
            RX_CHK: begin
                rdata_d = m_do;
                state_d = FINISH;
            end
            STOP_CR: begin
                m_we_d  = 1'b1;
                m_a_d   = 6'd4;
                m_di_d  = 8'h40;
                state_d = STOP_RD;
            end
            STOP_RD: begin
                m_re_d  = 1'b1;
                m_a_d   = 6'd4;
                state_d = STOP_WAIT;
            end
            STOP_WAIT: state_d = STOP_CHK;
            STOP_CHK: state_d = m_do[1] ? STOP_RD : FINISH;
            FINISH: state_d = IDLE;
            default: state_d = INIT_LO;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= INIT_LO;
            phase_q <= 2'd0;
            cnt_q   <= 16'd0;
            rnw_q   <= 1'b0;
            dev_q   <= 7'd0;
            reg_q   <= 8'd0;
            wdata_q <= 8'd0;
            rdata_q <= 8'd0;
            err_q   <= 2'd0;
            m_a_q   <= 6'd0;
            m_di_q  <= 8'd0;
            m_we_q  <= 1'b0;
            m_re_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            rnw_q   <= rnw_d;
            dev_q   <= dev_d;
            reg_q   <= reg_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            m_a_q   <= m_a_d;
            m_di_q  <= m_di_d;
            m_we_q  <= m_we_d;
            m_re_q  <= m_re_d;
        end
    end
endmodule

// File: tb/tb_i2c_xfer_sequencer.sv
// tb_i2c_xfer_sequencer: i2c_xfer_sequencer against a transaction-level
// i2c_master/slave model; bus traffic and results compared with expectations.
module tb_i2c_xfer_sequencer;
    logic       PCLK = 1'b0;
    logic       PRESETn = 1'b1;
    logic       req = 1'b0;
    logic       rnw = 1'b0;
    logic [6:0] dev_addr = 7'd0;
    logic [7:0] reg_addr = 8'd0;
    logic [7:0] wdata = 8'd0;
    logic       ready, done, m_we, m_re;
    logic [7:0] rdata, m_di;
    logic [1:0] err;
    logic [5:0] m_a;
    logic [7:0] m_do = 8'd0;

    int total = 0;
    int bad = 0;

    always #5 PCLK = ~PCLK;

    i2c_xfer_sequencer #(.PRESCALE(16'd99), .TIMEOUT(16'd8)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .req(req), .rnw(rnw),
        .dev_addr(dev_addr), .reg_addr(reg_addr), .wdata(wdata),
        .ready(ready), .done(done), .rdata(rdata), .err(err),
        .m_a(m_a), .m_di(m_di), .m_we(m_we), .m_re(m_re), .m_do(m_do)
    );

    // Core + single slave at 0x50, modelled per byte command rather than per bit
    logic [7:0]  mem [256];
    logic [7:0]  ref_mem [256];
    logic [13:0] wlog[$];
    logic [13:0] exp_q[$];
    logic [7:0]  txr_m = 8'd0, rxr_m = 8'd0, ptr_m = 8'd0;
    bit          dev_ok = 0, need_ptr = 0, rxack_m = 0, al_m = 0, tip_hold = 0;
    int          tip_left = 0, cr_cnt = 0, al_at = 0, polls = 0, polls_at_stop = 0, done_cnt = 0;

    always @(posedge PCLK) begin
        if (ready) cr_cnt = 0;
        if (done) done_cnt++;
        if (m_we) begin
            wlog.push_back({m_a, m_di});
            if (m_a == 6'd3) txr_m = m_di;
            if (m_a == 6'd4) begin
                cr_cnt++;
                al_m = 0;
                if (m_di == 8'h40) polls_at_stop = polls;
                polls = 0;
                if (m_di[7] && m_di[4]) begin
                    dev_ok   = txr_m[7:1] == 7'h50;
                    need_ptr = !txr_m[0];
                    rxack_m  = !dev_ok;
                end else if (m_di[4]) begin
                    rxack_m = !dev_ok;
                    if (dev_ok && need_ptr) begin
                        ptr_m    = txr_m;
                        need_ptr = 0;
                    end else if (dev_ok) begin
                        mem[ptr_m] = txr_m;
                        ptr_m++;
                    end
                end
                if (m_di[5]) rxr_m = mem[ptr_m];
                tip_left = $urandom_range(0, 3);
                if (tip_hold && m_di == 8'h40) begin
                    tip_hold = 0;
                    tip_left = 4;
                end
                if (cr_cnt == al_at) al_m = 1;
            end
        end
        if (m_re) begin
            if (m_a == 6'd4) begin
                polls++;
                m_do <= {rxack_m, 1'b0, al_m, 3'b000, tip_hold || tip_left > 0, 1'b0};
                if (tip_left > 0) tip_left--;
            end else begin
                m_do <= rxr_m;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [13:0] w(input logic [5:0] a, input logic [7:0] d);
        return {a, d};
    endfunction

    task automatic cmp_log(input string tag);
        chk({tag, "_len"}, 32'(wlog.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wlog.size(); i++)
            chk(tag, 32'(wlog[i]), 32'(exp_q[i]));
    endtask

    task automatic build_exp(input bit r, input logic [6:0] d, input logic [7:0] ra,
                             input logic [7:0] wd, input bit present);
        exp_q.delete();
        exp_q.push_back(w(6'd3, {d, 1'b0}));
        exp_q.push_back(w(6'd4, 8'h90));
        if (!present) begin
            exp_q.push_back(w(6'd4, 8'h40));
        end else begin
            exp_q.push_back(w(6'd3, ra));
            exp_q.push_back(w(6'd4, 8'h10));
            if (r) begin
                exp_q.push_back(w(6'd3, {d, 1'b1}));
                exp_q.push_back(w(6'd4, 8'h90));
                exp_q.push_back(w(6'd4, 8'h68));
            end else begin
                exp_q.push_back(w(6'd3, wd));
                exp_q.push_back(w(6'd4, 8'h50));
            end
        end
    endtask

    task automatic xfer(input bit r, input logic [6:0] d, input logic [7:0] ra,
                        input logic [7:0] wd, output logic [1:0] e, output logic [7:0] rd);
        int n;
        bit got;
        n = 0;
        while (!ready && n < 200) begin
            @(negedge PCLK);
            n++;
        end
        wlog.delete();
        rnw = r; dev_addr = d; reg_addr = ra; wdata = wd; req = 1'b1;
        @(negedge PCLK);
        req = 1'b0;
        chk("ready_drop", 32'(ready), 32'd0);
        got = 0; n = 0;
        while (!done && n < 2000) begin
            @(negedge PCLK);
            n++;
        end
        got = done;
        e = err;
        rd = rdata;
        chk("done_seen", 32'(got), 32'd1);
        @(negedge PCLK);
        chk("done_pulse", 32'(done), 32'd0);
        chk("ready_back", 32'(ready), 32'd1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] e;
        logic [7:0] rd, ra, wd;
        logic [6:0] d;
        bit r, present;
        int rc, d0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        #1 PRESETn = 1'b0;
        repeat (3) @(negedge PCLK);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bus", {m_we, m_re, m_a, m_di}, 32'd0);
        chk("rst_status", {rdata, err}, 32'd0);

        wlog.delete();
        PRESETn = 1'b1;
        rc = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge PCLK);
            if (ready && rc == 0) rc = c;
        end
        chk("ready_cycle", 32'(rc), 32'd3);
        exp_q = '{w(6'd0, 8'h63), w(6'd1, 8'h00), w(6'd2, 8'h80)};
        cmp_log("init");

        xfer(0, 7'h50, 8'h12, 8'hA5, e, rd);
        build_exp(0, 7'h50, 8'h12, 8'hA5, 1);
        ref_mem[8'h12] = 8'hA5;
        cmp_log("wr_bus");
        chk("wr_err", 32'(e), 32'd0);
        chk("wr_mem", 32'(mem[8'h12]), 32'hA5);

        mem[8'h12] = 8'h3C;
        ref_mem[8'h12] = 8'h3C;
        xfer(1, 7'h50, 8'h12, 8'h00, e, rd);
        build_exp(1, 7'h50, 8'h12, 8'h00, 1);
        cmp_log("rd_bus");
        chk("rd_err", 32'(e), 32'd0);
        chk("rd_data", 32'(rd), 32'h3C);
        repeat (3) @(negedge PCLK);
        chk("rd_hold", 32'(rdata), 32'h3C);

        xfer(0, 7'h22, 8'h05, 8'h77, e, rd);
        build_exp(0, 7'h22, 8'h05, 8'h77, 0);
        cmp_log("nack_bus");
        chk("nack_err", 32'(e), 32'd1);
        chk("nack_rdclr", 32'(rd), 32'd0);
        repeat (3) @(negedge PCLK);
        chk("nack_hold", 32'(err), 32'd1);

        tip_hold = 1;
        xfer(0, 7'h50, 8'h40, 8'h11, e, rd);
        exp_q = '{w(6'd3, 8'hA0), w(6'd4, 8'h90), w(6'd4, 8'h40)};
        cmp_log("to_bus");
        chk("to_err", 32'(e), 32'd3);
        chk("to_polls", 32'(polls_at_stop), 32'd8);

        al_at = 2;
        xfer(0, 7'h50, 8'h41, 8'h22, e, rd);
        repeat (20) @(negedge PCLK);
        al_at = 0;
        exp_q = '{w(6'd3, 8'hA0), w(6'd4, 8'h90), w(6'd3, 8'h41), w(6'd4, 8'h10)};
        cmp_log("al_bus");
        chk("al_err", 32'(e), 32'd2);

        for (int k = 0; k < 24; k++) begin
            present = $urandom_range(0, 3) != 0;
            d = present ? 7'h50 : 7'($urandom);
            if (!present && d == 7'h50) d = 7'h51;
            r = 1'($urandom);
            ra = 8'($urandom);
            wd = 8'($urandom);
            xfer(r, d, ra, wd, e, rd);
            build_exp(r, d, ra, wd, present);
            if (present && !r) ref_mem[ra] = wd;
            cmp_log("rnd_bus");
            chk("rnd_err", 32'(e), present ? 32'd0 : 32'd1);
            chk("rnd_rdata", 32'(rd), (present && r) ? 32'(ref_mem[ra]) : 32'd0);
            chk("rnd_mem", 32'(mem[ra]), 32'(ref_mem[ra]));
        end

        d0 = done_cnt;
        rnw = 1'b1; dev_addr = 7'h50; reg_addr = 8'h12; req = 1'b1;
        @(negedge PCLK);
        req = 1'b0;
        repeat (12) @(negedge PCLK);
        PRESETn = 1'b0;
        wlog.delete();
        repeat (2) @(negedge PCLK);
        chk("mid_rst_bus", {m_we, m_re}, 32'd0);
        PRESETn = 1'b1;
        repeat (8) @(negedge PCLK);
        chk("mid_rst_nodone", 32'(done_cnt), 32'(d0));
        exp_q = '{w(6'd0, 8'h63), w(6'd1, 8'h00), w(6'd2, 8'h80)};
        cmp_log("reinit");
        xfer(0, 7'h50, 8'h33, 8'h5A, e, rd);
        build_exp(0, 7'h50, 8'h33, 8'h5A, 1);
        cmp_log("post_wr_bus");
        chk("post_wr_err", 32'(e), 32'd0);
        chk("post_wr_mem", 32'(mem[8'h33]), 32'h5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/i2c_xfer_sequencer.md
Name: i2c_xfer_sequencer

Overview:
- Hardware sequencer that drives the register bus of the i2c_master core.
- Performs complete single-byte register writes and reads on an I2C slave (device address, register address, data) from a one-shot request.
- Sits between a simple requester (CPU-side register block or DMA-style engine) and i2c_master, so software does not hand-poll TIP/RxACK.
- Programs the prescaler and core enable once after reset.

Parameters:
PRESCALE, 16'd99, value written to PRERlo/PRERhi at init
TIMEOUT, 16'd4095, max SR polls per byte phase before abort

Ports:
PCLK  in  1  clock
PRESETn  in  1  asynchronous active-low reset
req  in  1  start transfer; accepted when req && ready
rnw  in  1  1=read, 0=write
dev_addr  in  7  7-bit slave address
reg_addr  in  8  slave register index
wdata  in  8  write byte
ready  out  1  idle, init complete
done  out  1  one-cycle pulse, transfer finished (ok or error)
rdata  out  8  read byte, held until next accepted req
err  out  2  status with done: 0 ok, 1 NACK, 2 arbitration lost, 3 timeout
m_a  out  6  i2c_master io_a (word index)
m_di  out  8  i2c_master io_di
m_we  out  1  i2c_master io_we
m_re  out  1  i2c_master io_re
m_do  in  8  i2c_master io_do; valid the cycle after m_re

Behaviour:
- Register map used (word index): 0 PRERlo, 1 PRERhi, 2 CTR, 3 TXR/RXR, 4 CR/SR.
- CR bits: STA 0x80, STO 0x40, RD 0x20, WR 0x10, ACK 0x08 (1 = send NACK).
- SR bits: RxACK b7, AL b5, TIP b1.
- Reset: all outputs 0, rdata 0, err 0, state INIT_LO.
- Every bus write is a single-cycle m_we pulse with m_a/m_di valid in that cycle; m_re is likewise single-cycle.
- Init: INIT_LO (PRERlo = PRESCALE[7:0]), INIT_HI (PRERhi = PRESCALE[15:8]), INIT_EN (CTR = 0x80), then IDLE.
- Init costs one cycle per write; ready rises the cycle IDLE is entered, 3 cycles after reset release.
- IDLE: ready = 1. On req, latch rnw/dev_addr/reg_addr/wdata and clear rdata/err; ready drops next cycle. req is ignored while ready = 0.
- Byte phase (generic step): SET_TXR (TXR write, skipped for the read-data phase), SET_CR, then POLL_RD/POLL_CHK.
  - POLL_RD: m_re to SR.
  - POLL_CHK: sample m_do.
    - AL = 1 -> error 2, go to FINISH without STOP.
    - TIP = 1 -> increment poll counter; if counter == TIMEOUT, error 3, else back to POLL_RD.
    - TIP = 0, non-read phase, RxACK = 1 -> error 1.
    - Otherwise next phase; poll counter clears at every phase start.
- Write sequence: (TXR = {dev,0}, CR = 0x90); (TXR = reg, CR = 0x10); (TXR = wdata, CR = 0x50).
- Read sequence: (TXR = {dev,0}, CR = 0x90); (TXR = reg, CR = 0x10); (TXR = {dev,1}, CR = 0x90); (CR = 0x68, no RxACK check); then RXR read: m_re at a=3, rdata = m_do next cycle.
- Errors 1 and 3: write CR = 0x40 (STOP), poll until TIP = 0 (no timeout on this poll, AL ignored), then FINISH.
- FINISH: done = 1 for one cycle, err valid in that cycle, then IDLE.
- err and rdata hold until the next accepted req.
- Reset mid-transfer aborts immediately, returns to INIT_LO and re-initialises the core; no done is issued.
- Write the prescaler only while the core is disabled: init ordering is fixed (PRER before CTR).

Test Plan:
- Reset release, PRESCALE = 99 -> exactly three m_we: (a0,0x63), (a1,0x00), (a2,0x80); ready = 1 on cycle 3.
- Write req dev = 0x50, reg = 0x12, wdata = 0xA5, slave ACKs all -> TXR/CR pairs (0xA0,0x90), (0x12,0x10), (0xA5,0x50); done with err = 0; slave model holds 0xA5 at 0x12.
- Read req dev = 0x50, reg = 0x12, slave returns 0x3C -> CR sequence 0x90, 0x10, 0x90 (TXR = 0xA1), 0x68; rdata = 0x3C, err = 0.
- No slave at dev = 0x22 -> RxACK = 1 after first byte -> CR = 0x40 issued; done with err = 1; ready returns 1.
- Model holds TIP = 1 forever, TIMEOUT = 8 -> 8 SR polls, then STOP write, done with err = 3 once TIP is released.
- AL asserted during second byte -> no STOP write, done with err = 2. Separately, PRESETn pulsed mid-read -> no done, init writes repeat, a following write completes.
